// File: rtl/udp_tx_packer.sv
// udp_tx_packer: packs a user byte stream big-endian into 32-bit words held in a
// one-frame buffer, then hands the frame to the UDP/IP MII sender.
//
// Ports:
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   wr_en, wr_data, wr_last   byte stream in; a byte is taken when wr_en & wr_ready
//   wr_ready                  high while filling a frame
//   send_en                   one-cycle pulse that starts a frame in the sender
//   send_data                 current payload word
//   send_data_num             valid payload bytes in the frame being sent
//   read_data_req             sender consumed send_data; advance to next word
//   send_end                  sender finished the frame
//   busy                      high while a frame is being handed over
//   frame_cnt                 frames completed, wraps modulo 2^16
module udp_tx_packer #(
    parameter int unsigned MAX_BYTES = 1024,
    parameter int unsigned TIMEOUT   = 5000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        wr_last,
    output logic        wr_ready,
    output logic        send_en,
    output logic [31:0] send_data,
    output logic [15:0] send_data_num,
    input  logic        read_data_req,
    input  logic        send_end,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int unsigned Depth = MAX_BYTES / 4;
    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned IdleW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] StFill  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StStart = 2'd2;
    localparam logic [1:0] StSend  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [15:0]      byte_cnt_q, byte_cnt_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [15:0]      num_q, num_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic             past_end_q, past_end_d;
    logic [31:0]      asm_q, asm_d;
    logic [31:0]      merged;
    logic [AddrW-1:0] last_word;

    logic             ram_we;
    logic [AddrW-1:0] ram_addr;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_rdata;
    logic [31:0]      mem [Depth];

    // Assembly word with the incoming byte placed in its lane; the first byte of a
    // word starts from zero so unwritten lanes of a partial word read as 0.
    always_comb begin
        if (byte_cnt_q[1:0] == 2'd0) begin
            merged = {wr_data, 24'h0};
        end else begin
            merged = asm_q | ({24'h0, wr_data} << {~byte_cnt_q[1:0], 3'b000});
        end
    end

    assign last_word = AddrW'((num_q - 16'd1) >> 2);

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        frame_cnt_d = frame_cnt_q;
        num_d       = num_q;
        rd_ptr_d    = rd_ptr_q;
        past_end_d  = past_end_q;
        asm_d       = asm_q;
        ram_we      = 1'b0;
        ram_addr    = rd_ptr_q;
        ram_wdata   = asm_q;

        unique case (state_q)
            StFill: begin
                if (wr_en) begin
                    asm_d      = merged;
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    idle_cnt_d = '0;
                    ram_addr   = AddrW'(byte_cnt_q >> 2);
                    ram_wdata  = merged;
                    if (wr_last || (byte_cnt_d == 16'(MAX_BYTES))) begin
                        ram_we  = 1'b1;
                        num_d   = byte_cnt_d;
                        state_d = StLoad;
                    end else if (byte_cnt_q[1:0] == 2'd3) begin
                        ram_we = 1'b1;
                    end
                end else if (byte_cnt_q != 16'd0) begin
                    if ((TIMEOUT != 0) && (idle_cnt_q == IdleW'(TIMEOUT))) begin
                        // Flush the word in progress; rewriting a completed word is harmless.
                        ram_we    = 1'b1;
                        ram_addr  = AddrW'((byte_cnt_q - 16'd1) >> 2);
                        ram_wdata = asm_q;
                        num_d     = byte_cnt_q;
                        state_d   = StLoad;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            StLoad: begin
                ram_addr   = '0;
                rd_ptr_d   = '0;
                past_end_d = 1'b0;
                state_d    = StStart;
            end
            StStart: begin
                ram_addr = rd_ptr_q;
                state_d  = StSend;
            end
            StSend: begin
                if (send_end) begin
                    state_d     = StFill;
                    byte_cnt_d  = '0;
                    idle_cnt_d  = '0;
                    rd_ptr_d    = '0;
                    past_end_d  = 1'b0;
                    num_d       = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else if (read_data_req) begin
                    if (rd_ptr_q == last_word) begin
                        past_end_d = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
                // Read ahead so the next word is on ram_rdata one cycle after the request.
                ram_addr = rd_ptr_d;
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= StFill;
            byte_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            frame_cnt_q <= '0;
            num_q       <= '0;
            rd_ptr_q    <= '0;
            past_end_q  <= 1'b0;
            asm_q       <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            num_q       <= num_d;
            rd_ptr_q    <= rd_ptr_d;
            past_end_q  <= past_end_d;
            asm_q       <= asm_d;
        end
    end

    // Single-port frame buffer with registered read.
    always_ff @(posedge sys_clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    assign wr_ready      = (state_q == StFill);
    assign busy          = (state_q != StFill);
    assign send_en       = (state_q == StStart);
    assign send_data_num = num_q;
    assign frame_cnt     = frame_cnt_q;
    assign send_data     = (((state_q == StStart) || (state_q == StSend)) && !past_end_q)
                           ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_udp_tx_packer.sv
// tb_udp_tx_packer: directed and randomized stimulus for udp_tx_packer, checked every
// cycle against a frame-level reference model (byte queues, scheduled send_en cycle).
module tb_udp_tx_packer;

    localparam int unsigned MaxBytes = 8;
    localparam int unsigned Timeout  = 20;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h0;
    logic        wr_last = 1'b0;
    logic        wr_ready;
    logic        send_en;
    logic [31:0] send_data;
    logic [15:0] send_data_num;
    logic        read_data_req = 1'b0;
    logic        send_end = 1'b0;
    logic        busy;
    logic [15:0] frame_cnt;

    udp_tx_packer #(
        .MAX_BYTES (MaxBytes),
        .TIMEOUT   (Timeout)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .wr_last       (wr_last),
        .wr_ready      (wr_ready),
        .send_en       (send_en),
        .send_data     (send_data),
        .send_data_num (send_data_num),
        .read_data_req (read_data_req),
        .send_end      (send_end),
        .busy          (busy),
        .frame_cnt     (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int         cyc = 0;
    logic [7:0] cur_q[$];
    logic [7:0] frm_q[$];
    logic       busy_m = 1'b0;
    int         start_cyc = -10;
    int         idx = 0;
    int         last_acc = 0;
    int         frames_done = 0;
    logic       accepted = 1'b0;
    logic       rst_seen = 1'b0;
    logic       chk_on = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_of(input int w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            if (w * 4 + b < frm_q.size()) r[31 - 8 * b -: 8] = frm_q[w * 4 + b];
        end
        return r;
    endfunction

    task automatic launch();
        frm_q     = cur_q;
        cur_q.delete();
        busy_m    = 1'b1;
        start_cyc = cyc + 2;
        idx       = 0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input logic en, input logic [7:0] d, input logic last,
                        input logic req, input logic fin, input logic rst);
        wr_en = en; wr_data = d; wr_last = last;
        read_data_req = req; send_end = fin; sys_rst = rst;
        @(negedge sys_clk);
        if (chk_on) begin
            check_eq("wr_ready", 32'(wr_ready), 32'(!busy_m));
            check_eq("busy", 32'(busy), 32'(busy_m));
            check_eq("send_en", 32'(send_en), 32'(busy_m && (cyc == start_cyc)));
            check_eq("send_data_num", 32'(send_data_num), busy_m ? 32'(frm_q.size()) : 32'd0);
            check_eq("frame_cnt", 32'(frame_cnt), 32'(frames_done[15:0]));
            if (busy_m && (cyc >= start_cyc)) check_eq("send_data", send_data, word_of(idx));
            if (rst_seen) check_eq("send_data_rst", send_data, 32'd0);
        end
        @(posedge sys_clk);
        accepted = 1'b0;
        if (rst) begin
            cur_q.delete();
            frm_q.delete();
            busy_m = 1'b0; start_cyc = -10; idx = 0; frames_done = 0;
            rst_seen = 1'b1;
        end else begin
            rst_seen = 1'b0;
            if (busy_m) begin
                if (cyc > start_cyc) begin
                    if (fin) begin
                        busy_m = 1'b0;
                        frames_done++;
                    end else if (req) begin
                        idx++;
                    end
                end
            end else if (en) begin
                accepted = 1'b1;
                cur_q.push_back(d);
                last_acc = cyc;
                if (last || (cur_q.size() == MaxBytes)) launch();
            end else if ((cur_q.size() != 0) && (Timeout != 0) && (cyc - last_acc == Timeout + 1)) begin
                launch();
            end
        end
        cyc++;
        #1;
    endtask

    // Offer a byte until taken; a frame in progress is read a little and then ended.
    task automatic put_byte(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 100) begin
            step(1'b1, d, last, busy_m && (cyc > start_cyc),
                 busy_m && (cyc == start_cyc + 3), 1'b0);
            n++;
        end
        check_eq("put_bound", 32'(accepted), 32'd1);
    endtask

    task automatic drain(input int nreq, input logic both);
        int n;
        n = 0;
        while (!(busy_m && (cyc > start_cyc)) && n < 60) begin
            step(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        for (int i = 0; i < nreq; i++) step(1'b0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h0, 1'b0, both, 1'b1, 1'b0);
        step(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("drain_done", 32'(busy), 32'd0);
    endtask

    logic       r_en, r_last, r_req, r_fin, r_rst, hold;
    logic [7:0] r_d;
    int         mode;

    initial begin
        @(posedge sys_clk);
        #1;
        step(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_on = 1'b1;
        step(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Five bytes with wr_last, two reads (second past the end).
        for (int i = 1; i <= 5; i++) put_byte(8'(i), i == 5);
        drain(2, 1'b0);

        // Ten bytes, no wr_last: split at MaxBytes, remainder flushed by timeout.
        for (int i = 0; i < 10; i++) put_byte(8'(i), 1'b0);
        drain(1, 1'b0);

        // Reset in the middle of SEND after one read.
        for (int i = 0; i < 3; i++) put_byte(8'hA0 + 8'(i), i == 2);
        while (!(busy_m && (cyc > start_cyc))) step(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        put_byte(8'h11, 1'b0); put_byte(8'h22, 1'b0);
        put_byte(8'h33, 1'b0); put_byte(8'h44, 1'b1);
        drain(0, 1'b0);

        // Sender strobes in FILL are ignored; req with send_end ends the frame.
        for (int i = 0; i < 3; i++) step(1'b0, 8'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'h7E, 1'b1, 1'b1, 1'b1, 1'b0);
        drain(0, 1'b1);

        // Randomized traffic; a byte refused while busy is held until taken.
        hold = 1'b0; r_en = 1'b0; r_d = 8'h0; r_last = 1'b0; mode = 0;
        for (int i = 0; i < 3000 && n_errors < 50; i++) begin
            if (i % 150 == 0) mode = int'($urandom_range(0, 2));
            if (!hold) begin
                if (mode == 0)      r_en = ($urandom_range(0, 9) < 8);
                else if (mode == 1) r_en = ($urandom_range(0, 9) < 3);
                else                r_en = ($urandom_range(0, 99) < 3);
                r_d    = 8'($urandom);
                r_last = ($urandom_range(0, 9) == 0);
            end
            r_req = 1'($urandom_range(0, 1));
            r_fin = ($urandom_range(0, 7) == 0);
            r_rst = ($urandom_range(0, 499) == 0);
            step(r_en, r_d, r_last, r_req, r_fin, r_rst);
            hold = r_en && !accepted && !r_rst;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
